uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Parametrised, double-buffered UART transmitter: successor to the fixed 8-bit, one-clock-per-bit transmitter in the low-power system.
- Adds a configurable data width and a configurable bit period.
- Adds an optional second stop bit, latched per frame.
- Adds a one-entry holding register with a valid/ready handshake, so the register-file/FIFO side can stream frames back-to-back with no idle gap.
- Sits between the TX FIFO/sync logic and the serial pin; TX_OUT drives the line directly.

## Interface
- DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 1: CLK cycles per serial bit; legal range ≥1.
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  frame payload; LSB transmitted first.
- DATA_VALID  input  1  payload/config valid; accepted on an edge where DATA_VALID=1 and DATA_READY=1.
- PAR_EN  input  1  parity bit enable; sampled at accept.
- PAR_TYPE  input  1  0 = even parity, 1 = odd parity; sampled at accept.
- STOP2  input  1  1 = two stop bits, 0 = one stop bit; sampled at accept.
- TX_OUT  output  1  serial line; idles high.
- BUSY  output  1  1 while a frame is on the line or the holding register is full.
- DATA_READY  output  1  holding register empty; combinational from registered state only.

## Operation
- **Holding register**
  - Stores P_DATA, PAR_EN, PAR_TYPE and STOP2 on accept.
  - Sets a full flag on accept.
  - DATA_VALID while DATA_READY=0 is ignored; the holding contents are not overwritten.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **Frame load.** A load occurs on an edge where the holding register is full and either:
  - the state is IDLE, or
  - the state is in the final tick of the final stop bit.
- **On a load:**
  - holding → shift register and frame config registers;
  - the full flag clears;
  - the parity bit is computed from the loaded data: even = XOR-reduce, odd = inverted XOR-reduce;
  - the state goes to START.
- **Transitions**, each after CLKS_PER_BIT ticks:
  - START → DATA.
  - DATA shifts out DATA_WIDTH bits, then goes to PARITY if PAR_EN, else to STOP.
  - PARITY → STOP.
  - STOP lasts 1 or 2 bit periods, per the latched STOP2. It then goes to START if a load occurs, else to IDLE.
- **TX_OUT decode**, from registered state only:
  - IDLE = 1;
  - START = 0;
  - DATA = shift register bit 0;
  - PARITY = latched parity bit;
  - STOP = 1.
- **Counters**
  - Tick counter: $clog2(CLKS_PER_BIT) bits, minimum 1 bit. Restarts at 0 on every bit boundary.
  - Bit counter: $clog2(DATA_WIDTH) bits. Counts DATA bits 0..DATA_WIDTH-1. Also counts stop bit 0..1.
- BUSY = (state ≠ IDLE) OR holding full.
- **Config changes.** Changing PAR_EN, PAR_TYPE or STOP2 mid-frame has no effect on the frame in flight. These inputs apply only to the next accepted word.
- **Reset (RST low), asynchronous, including mid-frame:**
  - state = IDLE, all counters 0, full flag 0, shift register 0;
  - TX_OUT = 1, BUSY = 0, DATA_READY = 1;
  - any partial frame is abandoned and held data is discarded.

## Timing
- Accept at edge E0 → load at E1 → START (TX_OUT = 0) is visible from E1 for CLKS_PER_BIT cycles.
- Accept-to-start-bit latency is 1 cycle.
- Frame length = (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) × CLKS_PER_BIT cycles.
- **Back-to-back.** When a second word is accepted while a frame is in flight:
  - its start bit follows the last stop bit on the next cycle, with zero idle cycles;
  - DATA_READY rises again on the load edge.
- Accept and load never coincide on the same edge, because DATA_READY=0 whenever the holding register is full.
- **Throughput:** one frame per frame length. Sustained streaming keeps BUSY = 1 continuously.

## Test plan
- **Reset values.** Hold RST low, then release.
  - Required: TX_OUT=1, BUSY=0, DATA_READY=1.
  - Required: no line activity while DATA_VALID=0.
- **Basic frame.** DATA_WIDTH=8, CLKS_PER_BIT=1, P_DATA=0xA5, PAR_EN=0, STOP2=0.
  - Required: from E1, TX_OUT = 0,1,0,1,0,0,1,0,1,1.
  - Required: BUSY falls after 10 cycles.
- **Parity types.** P_DATA=0x03, PAR_EN=1.
  - PAR_TYPE=0 → parity bit 0.
  - PAR_TYPE=1 → parity bit 1.
  - Required: frame is 11 cycles.
- **Back-to-back with two stop bits.** CLKS_PER_BIT=4, STOP2=1. Send 0x55, then 0x0F accepted mid-frame.
  - Required: each frame is 44 cycles, with no idle between frames.
  - Required: DATA_READY is 0 from the 0x0F accept until its load edge.
  - Required: a third DATA_VALID while DATA_READY=0 is ignored.
- **Config latching.** Toggle PAR_EN, PAR_TYPE and STOP2 during the DATA bits of a frame.
  - Required: the in-flight frame is unchanged.
  - Required: the next frame uses the values present at its own accept.
- **Reset mid-frame.** Assert RST during DATA bit 3 with the holding register full.
  - Required: TX_OUT=1 immediately (asynchronous).
  - Required: after release, BUSY=0 and DATA_READY=1, and no frame resumes.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Double-buffered UART transmitter: one-entry holding register with valid/ready
// in front of a start/data/parity/stop serialiser with configurable bit period.
module uart_tx_buffered #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYPE,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  DATA_READY
);

    localparam int unsigned TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = $clog2(DATA_WIDTH);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [TICK_W-1:0]      tick_q;
    logic [BIT_W-1:0]       bit_q;

    logic [DATA_WIDTH-1:0]  hold_data_q;
    logic                   hold_par_en_q;
    logic                   hold_par_type_q;
    logic                   hold_stop2_q;
    logic                   full_q;

    logic [DATA_WIDTH-1:0]  shift_q;
    logic                   par_en_q;
    logic                   stop2_q;
    logic                   par_bit_q;

    logic                   tick_last_c;
    logic                   bit_last_c;
    logic                   stop_last_c;
    logic                   accept_c;
    logic                   load_c;

    assign tick_last_c = (tick_q == TICK_LAST);
    assign bit_last_c  = (bit_q == BIT_LAST);
    assign stop_last_c = !stop2_q || (bit_q == STOP_LAST);
    assign accept_c    = DATA_VALID && !full_q;

    // A held word loads when the line is idle or on the very last tick of the
    // last stop bit, so back-to-back frames have no idle cycle between them.
    assign load_c = full_q &&
                    ((state_q == IDLE) ||
                     ((state_q == STOP) && tick_last_c && stop_last_c));

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            START: begin
                if (tick_last_c) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick_last_c && bit_last_c) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick_last_c) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick_last_c && stop_last_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load_c) begin
            state_d = START;
        end
    end

    // Tick counter restarts on every bit boundary and stays at zero while idle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tick_q <= '0;
        end else if (load_c || (state_q == IDLE) || tick_last_c) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + TICK_W'(1);
        end
    end

    // Bit counter indexes data bits, then reuses itself to count stop bits
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_q <= '0;
        end else if (load_c) begin
            bit_q <= '0;
        end else if (tick_last_c) begin
            case (state_q)
                DATA:    bit_q <= bit_last_c  ? '0 : bit_q + BIT_W'(1);
                STOP:    bit_q <= stop_last_c ? '0 : bit_q + BIT_W'(1);
                default: bit_q <= '0;
            endcase
        end
    end

    // Holding register: filled on accept, drained on load
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_data_q     <= '0;
            hold_par_en_q   <= 1'b0;
            hold_par_type_q <= 1'b0;
            hold_stop2_q    <= 1'b0;
            full_q          <= 1'b0;
        end else if (accept_c) begin
            hold_data_q     <= P_DATA;
            hold_par_en_q   <= PAR_EN;
            hold_par_type_q <= PAR_TYPE;
            hold_stop2_q    <= STOP2;
            full_q          <= 1'b1;
        end else if (load_c) begin
            full_q          <= 1'b0;
        end
    end

    // Frame registers: config is frozen at load so the frame in flight never changes
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (load_c) begin
            shift_q   <= hold_data_q;
            par_en_q  <= hold_par_en_q;
            stop2_q   <= hold_stop2_q;
            par_bit_q <= (^hold_data_q) ^ hold_par_type_q;
        end else if ((state_q == DATA) && tick_last_c) begin
            shift_q   <= shift_q >> 1;
        end
    end

    // Line decode from registered state only
    always_comb begin
        TX_OUT = 1'b1;
        case (state_q)
            IDLE:    TX_OUT = 1'b1;
            START:   TX_OUT = 1'b0;
            DATA:    TX_OUT = shift_q[0];
            PARITY:  TX_OUT = par_bit_q;
            STOP:    TX_OUT = 1'b1;
            default: TX_OUT = 1'b1;
        endcase
    end

    assign BUSY       = (state_q != IDLE) || full_q;
    assign DATA_READY = !full_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: stimulus queues hand-written frame
// bit strings, per-instance monitors capture TX_OUT frames and compare.
module tb_uart_tx_buffered;

    localparam int unsigned DW = 8;

    typedef struct packed {
        logic [15:0] bits;
        logic [7:0]  len;
        logic        btb;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [DW-1:0] d1_data, d4_data;
    logic          d1_valid, d1_par_en, d1_par_type, d1_stop2;
    logic          d4_valid, d4_par_en, d4_par_type, d4_stop2;
    logic          tx1, busy1, rdy1;
    logic          tx4, busy4, rdy4;

    exp_t q1[$];
    exp_t q4[$];
    int   n_cmp = 0;
    int   n_err = 0;

    uart_tx_buffered #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1)) u_dut1 (
        .CLK(clk), .RST(rst_n), .P_DATA(d1_data), .DATA_VALID(d1_valid),
        .PAR_EN(d1_par_en), .PAR_TYPE(d1_par_type), .STOP2(d1_stop2),
        .TX_OUT(tx1), .BUSY(busy1), .DATA_READY(rdy1)
    );

    uart_tx_buffered #(.DATA_WIDTH(DW), .CLKS_PER_BIT(4)) u_dut4 (
        .CLK(clk), .RST(rst_n), .P_DATA(d4_data), .DATA_VALID(d4_valid),
        .PAR_EN(d4_par_en), .PAR_TYPE(d4_par_type), .STOP2(d4_stop2),
        .TX_OUT(tx4), .BUSY(busy4), .DATA_READY(rdy4)
    );

    function automatic exp_t mk_exp(input string s, input logic btb);
        exp_t e;
        e.bits = '0;
        e.len  = 8'(s.len());
        e.btb  = btb;
        for (int i = 0; i < s.len(); i++) begin
            e.bits[i] = (s[i] == 8'h31);
        end
        return e;
    endfunction

    function automatic logic get_tx(input int idx);
        return (idx == 0) ? tx1 : tx4;
    endfunction

    function automatic logic get_busy(input int idx);
        return (idx == 0) ? busy1 : busy4;
    endfunction

    function automatic logic get_rdy(input int idx);
        return (idx == 0) ? rdy1 : rdy4;
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic drive(input int idx, input logic v, input logic [DW-1:0] d,
                         input logic pe, input logic pt, input logic s2);
        if (idx == 0) begin
            d1_valid = v; d1_data = d; d1_par_en = pe; d1_par_type = pt; d1_stop2 = s2;
        end else begin
            d4_valid = v; d4_data = d; d4_par_en = pe; d4_par_type = pt; d4_stop2 = s2;
        end
    endtask

    task automatic set_valid(input int idx, input logic v);
        if (idx == 0) d1_valid = v;
        else          d4_valid = v;
    endtask

    // Waits for ready, presents one word for exactly one edge, queues its frame
    task automatic send(input int idx, input logic [DW-1:0] d, input logic pe,
                        input logic pt, input logic s2, input string frame,
                        input logic btb);
        int n;
        n = 0;
        @(negedge clk);
        while (!get_rdy(idx) && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!get_rdy(idx)) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout dut%0d: ready stayed 0, required 1", idx);
            return;
        end
        drive(idx, 1'b1, d, pe, pt, s2);
        if (idx == 0) q1.push_back(mk_exp(frame, btb));
        else          q4.push_back(mk_exp(frame, btb));
        @(posedge clk);
        @(negedge clk);
        set_valid(idx, 1'b0);
    endtask

    // Counts consecutive negedge samples with BUSY high, starting at the current one
    task automatic count_busy(input int idx, output int n);
        n = 0;
        while (get_busy(idx) && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic monitor(input int idx, input int cpb);
        exp_t        e;
        logic [63:0] got, want;
        int          pos, samp, last_end, flen;
        logic        active, cur;
        active   = 1'b0;
        samp     = 0;
        last_end = -100;
        pos      = 0;
        flen     = 0;
        e        = '0;
        got      = '0;
        want     = '0;
        forever begin
            @(negedge clk);
            samp++;
            cur = get_tx(idx);
            if (!rst_n) begin
                active = 1'b0;
                if (idx == 0) q1.delete();
                else          q4.delete();
                continue;
            end
            if (!active && cur == 1'b0) begin
                if (((idx == 0) ? q1.size() : q4.size()) == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_frame dut%0d: start bit at sample %0d, required none", idx, samp);
                end else begin
                    e      = (idx == 0) ? q1.pop_front() : q4.pop_front();
                    active = 1'b1;
                    pos    = 0;
                    got    = '0;
                    want   = '0;
                    flen   = int'(e.len) * cpb;
                    for (int c = 0; c < flen; c++) want[c] = e.bits[c / cpb];
                    if (e.btb) begin
                        n_cmp++;
                        if (samp != last_end + 1) begin
                            n_err++;
                            $display("FAIL frame_gap dut%0d: idle cycles %0d, required 0", idx, samp - last_end - 1);
                        end
                    end
                end
            end
            if (active) begin
                got[pos] = cur;
                pos++;
                if (pos == flen) begin
                    n_cmp++;
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL frame_dut%0d: got %0h, required %0h (%0d cycles)", idx, got, want, flen);
                    end
                    active   = 1'b0;
                    last_end = samp;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lows;
        rst_n = 1'b0;
        drive(0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        fork
            monitor(0, 1);
            monitor(1, 4);
        join_none

        // Reset values
        repeat (2) @(negedge clk);
        check("reset_tx", int'(tx1), 1);
        check("reset_busy", int'(busy1), 0);
        check("reset_ready", int'(rdy1), 1);
        check("reset_tx_cpb4", int'(tx4), 1);
        #2 rst_n = 1'b1;
        lows = 0;
        repeat (10) begin
            @(negedge clk);
            if (!tx1 || !tx4 || busy1 || busy4) lows++;
        end
        check("idle_line_activity", lows, 0);

        // Basic frame 0xA5
        send(0, 8'hA5, 1'b0, 1'b0, 1'b0, "0101001011", 1'b0);
        @(negedge clk);
        count_busy(0, n);
        check("basic_busy_cycles", n, 10);

        // Parity types on 0x03
        send(0, 8'h03, 1'b1, 1'b0, 1'b0, "01100000001", 1'b0);
        @(negedge clk);
        count_busy(0, n);
        check("even_parity_busy_cycles", n, 11);
        send(0, 8'h03, 1'b1, 1'b1, 1'b0, "01100000011", 1'b0);
        @(negedge clk);
        count_busy(0, n);
        check("odd_parity_busy_cycles", n, 11);

        // Back-to-back, two stop bits, third word ignored while full
        send(1, 8'h55, 1'b0, 1'b0, 1'b1, "01010101011", 1'b0);
        send(1, 8'h0F, 1'b0, 1'b0, 1'b1, "01111000011", 1'b1);
        drive(1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (!rdy4 && n < 200) begin
            n++;
            @(negedge clk);
        end
        set_valid(1, 1'b0);
        check("ready_low_until_load", n, 43);
        count_busy(1, n);
        check("second_frame_busy_cycles", n, 44);

        // Config latching: toggle during DATA bits, next word takes new values
        repeat (3) @(negedge clk);
        send(1, 8'h3C, 1'b1, 1'b1, 1'b0, "00011110011", 1'b0);
        repeat (6) @(negedge clk);
        drive(1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        send(1, 8'hC3, 1'b0, 1'b0, 1'b1, "01100001111", 1'b1);
        count_busy(1, n);
        repeat (3) @(negedge clk);

        // Reset during DATA bit 3 with the holding register full
        send(1, 8'hF0, 1'b0, 1'b0, 1'b0, "0000011111", 1'b0);
        send(1, 8'h11, 1'b0, 1'b0, 1'b0, "0100010001", 1'b1);
        repeat (16) @(negedge clk);
        check("pre_reset_data_bit3", int'(tx4), 0);
        check("pre_reset_full", int'(rdy4), 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_tx", int'(tx4), 1);
        check("async_reset_busy", int'(busy4), 0);
        check("async_reset_ready", int'(rdy4), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", int'(busy4), 0);
        check("post_reset_ready", int'(rdy4), 1);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (!tx4 || busy4) lows++;
        end
        check("no_frame_resumes", lows, 0);

        check("scoreboard_drained_dut1", q1.size(), 0);
        check("scoreboard_drained_dut4", q4.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
